phy_pattern_gen: RTL
====================

Name: phy_pattern_gen

Overview:
- Synthesizable, parametrised frame/pattern generator that drives the PHY transmit stream (txd/tvalid/tready/terr) of phy_top.
- Generalises the fixed counter stimulus used during PHY bring-up: configurable data width, frame length, inter-frame gap, frame count, payload mode and error injection.
- Runs in hardware for on-board link tests and in simulation as bench stimulus.

Parameters:
- DATA_WIDTH, 8, stream data width in bits; multiple of 8, range 8..16.
- LEN_WIDTH, 16, width of frame-length and error-beat fields.
- IFG_WIDTH, 8, width of inter-frame gap field.
- LFSR_SEED, 16'hACE1, LFSR load value at each start; must be non-zero.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  reset, asynchronous, active-high.
- cfg_start  in  1  single-cycle start pulse; sampled only in IDLE.
- cfg_stop  in  1  single-cycle stop request; honoured at the next frame boundary.
- cfg_mode  in  2  payload mode: 0 incrementing, 1 constant fill, 2 LFSR, 3 reserved (acts as 0).
- cfg_frame_len  in  LEN_WIDTH  beats per frame; 0 is treated as 1.
- cfg_ifg  in  IFG_WIDTH  idle cycles between frames.
- cfg_frame_cnt  in  16  frames to send; 0 means continuous.
- cfg_fill  in  DATA_WIDTH  payload for mode 1.
- cfg_err_en  in  1  enables error injection.
- cfg_err_beat  in  LEN_WIDTH  beat index (0-based) that carries terr.
- phy_txd_out  out  DATA_WIDTH  stream data.
- phy_tvalid_out  out  1  data valid.
- phy_tready_in  in  1  sink ready.
- phy_terr_out  out  1  error flag, qualified by tvalid.
- phy_tlast_out  out  1  final beat of frame, qualified by tvalid.
- stat_busy  out  1  high outside IDLE.
- stat_frames  out  16  completed frames since start; saturates at 16'hFFFF.

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-frame. FSM goes to IDLE. All outputs and stats go to 0. LFSR loads LFSR_SEED.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - On cfg_start, latch all cfg_* inputs.
  - Clear stat_frames and the beat counter; load LFSR_SEED.
  - Go to SEND. The first beat has tvalid=1 on the cycle after the start pulse.
- SEND:
  - tvalid=1.
  - A handshake is tvalid & tready. With no handshake, txd/terr/tlast hold stable.
  - Each handshake increments the beat counter and advances the payload.
  - tlast=1 when beat counter == frame_len-1.
  - terr=1 when cfg_err_en and beat counter == cfg_err_beat. If cfg_err_beat >= frame_len, terr never asserts.
  - On the tlast handshake: stat_frames increments (saturating) and the beat counter clears.
  - Exit from the tlast handshake:
    - to IDLE if the frame count is reached (cfg_frame_cnt != 0) or a stop is pending;
    - otherwise to GAP if cfg_ifg != 0;
    - otherwise stay in SEND, giving back-to-back frames with tvalid continuously high.
- GAP:
  - tvalid=0 for exactly cfg_ifg cycles, then SEND.
  - A stop that arrives during GAP goes to IDLE at the end of the gap without starting a new frame.
- Payload:
  - Mode 0: txd = beat counter truncated to DATA_WIDTH; restarts at 0 each frame.
  - Mode 1: txd = latched cfg_fill.
  - Mode 2: txd = LFSR[DATA_WIDTH-1:0].
    - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
    - Advances one step per handshake; continues across frames.
    - First beat after start = LFSR_SEED[DATA_WIDTH-1:0].
- Stop: cfg_stop sets a sticky pending flag. The frame in progress always completes with its tlast; no truncated frames. The flag clears in IDLE.
- cfg_start while busy is ignored. Simultaneous cfg_start and cfg_stop in IDLE starts normally with stop pending, so exactly one frame is sent.
- Config inputs may change while busy with no effect until the next start.
- Latency: start pulse to first valid = 1 cycle. tlast handshake to next first beat = cfg_ifg+1 cycles when cfg_ifg > 0, or the next cycle when cfg_ifg = 0.

Test Plan:
- Mode 0, frame_len=4, ifg=2, frame_cnt=2, tready=1 → txd 0,1,2,3 (tlast on 3), 2 idle cycles, 0,1,2,3, IDLE; stat_frames=2, stat_busy falls.
- Mode 2, DATA_WIDTH=8, tready toggling 1010… → txd starts 8'hE1, held stable while tready=0, sequence matches the reference LFSR model; no beat lost or duplicated.
- Error injection: err_en=1, err_beat=2, frame_len=5 → terr only on beat 2 of every frame. Then err_beat=7 → terr never asserts.
- Continuous mode (frame_cnt=0, ifg=0), cfg_stop pulsed on beat 1 of frame 3 → frame 3 completes with tlast, then IDLE; tvalid continuously high until then.
- frame_len=0, mode 1, fill=8'h5A → single-beat frames, each txd=8'h5A with tlast=1.
- sys_rst asserted mid-frame (asynchronous, between clock edges) → tvalid/tlast/terr/stat_* drop to 0 immediately. A start after release begins a fresh frame at beat 0 with a reseeded LFSR.

Source files
------------

// File: rtl/phy_pattern_gen.sv
// phy_pattern_gen: frame/pattern generator for the PHY transmit stream.
// Sends cfg_frame_cnt frames (0 = continuous) of cfg_frame_len beats with
// cfg_ifg idle cycles between frames. The payload is an incrementing count,
// a constant fill or a 16-bit LFSR. terr can be injected on one beat per frame.
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   cfg_*                   configuration, latched on cfg_start in IDLE
//   phy_txd/tvalid/tready   transmit stream (valid/ready handshake)
//   phy_terr/tlast          per-beat error and end-of-frame flags
//   stat_busy, stat_frames  activity flag and completed-frame count
module phy_pattern_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned IFG_WIDTH  = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [IFG_WIDTH-1:0]  cfg_ifg,
  input  logic [15:0]           cfg_frame_cnt,
  input  logic [DATA_WIDTH-1:0] cfg_fill,
  input  logic                  cfg_err_en,
  input  logic [LEN_WIDTH-1:0]  cfg_err_beat,
  output logic [DATA_WIDTH-1:0] phy_txd_out,
  output logic                  phy_tvalid_out,
  input  logic                  phy_tready_in,
  output logic                  phy_terr_out,
  output logic                  phy_tlast_out,
  output logic                  stat_busy,
  output logic [15:0]           stat_frames
);

  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned LFSR_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [IFG_WIDTH-1:0]   ifg_q, ifg_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  fill_q, fill_d;
  logic                   err_en_q, err_en_d;
  logic [LEN_WIDTH-1:0]   err_beat_q, err_beat_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [IFG_WIDTH-1:0]   gap_q, gap_d;
  logic                   stop_q, stop_d;
  logic [CNT_WIDTH-1:0]   frames_d;
  logic [CNT_WIDTH-1:0]   frames_inc;
  logic                   stop_now;
  logic [DATA_WIDTH-1:0]  txd_d;
  logic                   tvalid_d, tlast_d, terr_d, busy_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[LFSR_WIDTH-1:1]};
  endfunction

  // Payload for a given beat; reserved mode 3 behaves as the counter.
  function automatic logic [DATA_WIDTH-1:0] payload(
    input logic [1:0]            mode,
    input logic [LEN_WIDTH-1:0]  beat,
    input logic [LFSR_WIDTH-1:0] lfsr,
    input logic [DATA_WIDTH-1:0] fill
  );
    case (mode)
      2'd1:    payload = fill;
      2'd2:    payload = lfsr[DATA_WIDTH-1:0];
      default: payload = DATA_WIDTH'(beat);
    endcase
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    ifg_d      = ifg_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    err_en_d   = err_en_q;
    err_beat_d = err_beat_q;
    beat_d     = beat_q;
    lfsr_d     = lfsr_q;
    gap_d      = gap_q;
    stop_d     = stop_q;
    frames_d   = stat_frames;
    frames_inc = (stat_frames == '1) ? stat_frames : stat_frames + CNT_WIDTH'(1);
    stop_now   = stop_q | cfg_stop;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (cfg_start) begin
          mode_d     = cfg_mode;
          len_d      = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
          ifg_d      = cfg_ifg;
          cnt_d      = cfg_frame_cnt;
          fill_d     = cfg_fill;
          err_en_d   = cfg_err_en;
          err_beat_d = cfg_err_beat;
          beat_d     = '0;
          lfsr_d     = LFSR_SEED;
          frames_d   = '0;
          stop_d     = cfg_stop;
          state_d    = SEND;
        end
      end
      SEND: begin
        stop_d = stop_now;
        if (phy_tvalid_out && phy_tready_in) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (phy_tlast_out) begin
            beat_d   = '0;
            frames_d = frames_inc;
            // A stop arriving on the last beat itself still ends the run here.
            if (((cnt_q != '0) && (frames_inc == cnt_q)) || stop_now) begin
              state_d = IDLE;
            end else if (ifg_q != '0) begin
              state_d = GAP;
              gap_d   = ifg_q;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      GAP: begin
        stop_d = stop_now;
        if (gap_q <= IFG_WIDTH'(1)) begin
          state_d = stop_now ? IDLE : SEND;
        end else begin
          gap_d = gap_q - IFG_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next beat; with no handshake nothing moves, so they hold.
    tvalid_d = (state_d == SEND);
    busy_d   = (state_d != IDLE);
    txd_d    = '0;
    tlast_d  = 1'b0;
    terr_d   = 1'b0;
    if (state_d == SEND) begin
      txd_d   = payload(mode_d, beat_d, lfsr_d, fill_d);
      tlast_d = (beat_d == len_d - LEN_WIDTH'(1));
      terr_d  = err_en_d && (beat_d == err_beat_d);
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      mode_q         <= '0;
      len_q          <= LEN_WIDTH'(1);
      ifg_q          <= '0;
      cnt_q          <= '0;
      fill_q         <= '0;
      err_en_q       <= 1'b0;
      err_beat_q     <= '0;
      beat_q         <= '0;
      lfsr_q         <= LFSR_SEED;
      gap_q          <= '0;
      stop_q         <= 1'b0;
      stat_frames    <= '0;
      stat_busy      <= 1'b0;
      phy_txd_out    <= '0;
      phy_tvalid_out <= 1'b0;
      phy_tlast_out  <= 1'b0;
      phy_terr_out   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      len_q          <= len_d;
      ifg_q          <= ifg_d;
      cnt_q          <= cnt_d;
      fill_q         <= fill_d;
      err_en_q       <= err_en_d;
      err_beat_q     <= err_beat_d;
      beat_q         <= beat_d;
      lfsr_q         <= lfsr_d;
      gap_q          <= gap_d;
      stop_q         <= stop_d;
      stat_frames    <= frames_d;
      stat_busy      <= busy_d;
      phy_txd_out    <= txd_d;
      phy_tvalid_out <= tvalid_d;
      phy_tlast_out  <= tlast_d;
      phy_terr_out   <= terr_d;
    end
  end

endmodule
